// File: rtl/board_state_ctrl.sv
// Tic-tac-toe board holder: cursor navigation, move placement and result latching.
// Optional one-level undo is built only when BOARD_UNDO_EN is defined.
module board_state_ctrl #(
    parameter logic       START_PLAYER = 1'b0,
    parameter logic [3:0] CURSOR_HOME  = 4'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_place,
    input  logic       btn_undo,
    input  logic       new_game,
    input  logic       win_x,
    input  logic       win_o,
    input  logic       no_space,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [3:0] cursor,
    output logic       turn,
    output logic [1:0] result,
    output logic       game_over,
    output logic       move_accepted,
    output logic       move_rejected
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    function automatic logic [3:0] cursor_inc(input logic [3:0] c);
        if (c >= 4'd9) return 4'd1;
        else           return c + 4'd1;
    endfunction

    function automatic logic [3:0] cursor_dec(input logic [3:0] c);
        if (c <= 4'd1) return 4'd9;
        else           return c - 4'd1;
    endfunction

    state_t           state_r, state_s;
    logic [8:0][1:0]  cells_r, cells_s;
    logic [3:0]       cursor_r, cursor_s;
    logic             turn_r, turn_s;
    logic [1:0]       result_r, result_s;
    logic             game_over_r, game_over_s;
    logic             accepted_r, accepted_s;
    logic             rejected_r, rejected_s;
    logic [3:0]       place_idx_s;
    logic             undo_go_s;

`ifdef BOARD_UNDO_EN
    logic             rec_valid_r, rec_valid_s;
    logic [3:0]       rec_cell_r, rec_cell_s;
    logic             rec_player_r, rec_player_s;
    assign undo_go_s = btn_undo & rec_valid_r;
`else
    assign undo_go_s = btn_undo & 1'b0;
`endif

    assign place_idx_s = cursor_r - 4'd1;

    // Next-state and next-output logic for board, cursor, turn and result
    always_comb begin
        state_s     = state_r;
        cells_s     = cells_r;
        cursor_s    = cursor_r;
        turn_s      = turn_r;
        result_s    = result_r;
        game_over_s = game_over_r;
        accepted_s  = 1'b0;
        rejected_s  = 1'b0;
`ifdef BOARD_UNDO_EN
        rec_valid_s  = rec_valid_r;
        rec_cell_s   = rec_cell_r;
        rec_player_s = rec_player_r;
`endif
        if (new_game) begin
            state_s     = ST_PLAY;
            cells_s     = 18'd0;
            cursor_s    = CURSOR_HOME;
            turn_s      = START_PLAYER;
            result_s    = 2'b00;
            game_over_s = 1'b0;
`ifdef BOARD_UNDO_EN
            rec_valid_s = 1'b0;
`endif
        end else begin
            // Navigation is live in PLAY and CHECK; opposing buttons cancel
            if (state_r != ST_OVER && btn_next && !btn_prev) begin
                cursor_s = cursor_inc(cursor_r);
            end else if (state_r != ST_OVER && btn_prev && !btn_next) begin
                cursor_s = cursor_dec(cursor_r);
            end else begin
                cursor_s = cursor_r;
            end

            case (state_r)
                ST_PLAY: begin
                    if (undo_go_s) begin
`ifdef BOARD_UNDO_EN
                        cells_s[rec_cell_r] = 2'b00;
                        turn_s              = rec_player_r;
                        cursor_s            = rec_cell_r + 4'd1;
                        rec_valid_s         = 1'b0;
`endif
                    end else if (btn_place) begin
                        if (cells_r[place_idx_s] == 2'b00) begin
                            cells_s[place_idx_s] = turn_r ? 2'b10 : 2'b01;
                            turn_s               = ~turn_r;
                            accepted_s           = 1'b1;
                            state_s              = ST_CHECK;
`ifdef BOARD_UNDO_EN
                            rec_valid_s  = 1'b1;
                            rec_cell_s   = place_idx_s;
                            rec_player_s = turn_r;
`endif
                        end else begin
                            rejected_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_CHECK: begin
                    // X has priority, and any win outranks a full board
                    if (win_x) begin
                        result_s = 2'b01;
                    end else if (win_o) begin
                        result_s = 2'b10;
                    end else if (no_space) begin
                        result_s = 2'b11;
                    end else begin
                        result_s = 2'b00;
                    end
                    if (win_x || win_o || no_space) begin
                        state_s     = ST_OVER;
                        game_over_s = 1'b1;
                    end else begin
                        state_s = ST_PLAY;
                    end
                end
                ST_OVER: begin
                    state_s = ST_OVER;
                end
                default: begin
                    state_s = ST_PLAY;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_PLAY;
            cells_r     <= 18'd0;
            cursor_r    <= CURSOR_HOME;
            turn_r      <= START_PLAYER;
            result_r    <= 2'b00;
            game_over_r <= 1'b0;
            accepted_r  <= 1'b0;
            rejected_r  <= 1'b0;
`ifdef BOARD_UNDO_EN
            rec_valid_r  <= 1'b0;
            rec_cell_r   <= 4'd0;
            rec_player_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cells_r     <= cells_s;
            cursor_r    <= cursor_s;
            turn_r      <= turn_s;
            result_r    <= result_s;
            game_over_r <= game_over_s;
            accepted_r  <= accepted_s;
            rejected_r  <= rejected_s;
`ifdef BOARD_UNDO_EN
            rec_valid_r  <= rec_valid_s;
            rec_cell_r   <= rec_cell_s;
            rec_player_r <= rec_player_s;
`endif
        end
    end

    assign pos1          = cells_r[0];
    assign pos2          = cells_r[1];
    assign pos3          = cells_r[2];
    assign pos4          = cells_r[3];
    assign pos5          = cells_r[4];
    assign pos6          = cells_r[5];
    assign pos7          = cells_r[6];
    assign pos8          = cells_r[7];
    assign pos9          = cells_r[8];
    assign cursor        = cursor_r;
    assign turn          = turn_r;
    assign result        = result_r;
    assign game_over     = game_over_r;
    assign move_accepted = accepted_r;
    assign move_rejected = rejected_r;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Scoreboard bench for board_state_ctrl: stimulus queues expected events,
// a negedge monitor pops them on accept/reject pulses, game_over rise or snapshot requests.
module tb_board_state_ctrl;

    localparam logic [1:0] K_SNAP = 2'd0;
    localparam logic [1:0] K_ACC  = 2'd1;
    localparam logic [1:0] K_REJ  = 2'd2;
    localparam logic [1:0] K_OVER = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [17:0] board;
        logic [3:0]  cursor;
        logic        turn;
        logic [1:0]  result;
        logic        over;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, btn_next, btn_prev, btn_place, btn_undo, new_game;
    logic win_x, win_o, no_space;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [3:0] cursor;
    logic turn, game_over, move_accepted, move_rejected;
    logic [1:0] result;

    logic snap_req = 1'b0;
    logic mon_stop = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic [8:0][1:0] exp_board;
    logic [3:0]      exp_cursor;
    logic            exp_turn;
    logic [1:0]      exp_result;
    logic            exp_over;

    board_state_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_next(btn_next), .btn_prev(btn_prev), .btn_place(btn_place),
        .btn_undo(btn_undo), .new_game(new_game),
        .win_x(win_x), .win_o(win_o), .no_space(no_space),
        .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
        .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
        .cursor(cursor), .turn(turn), .result(result), .game_over(game_over),
        .move_accepted(move_accepted), .move_rejected(move_rejected)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [1:0] kind);
        exp_t e;
        e.kind   = kind;
        e.board  = exp_board;
        e.cursor = exp_cursor;
        e.turn   = exp_turn;
        e.result = exp_result;
        e.over   = exp_over;
        exp_q.push_back(e);
    endtask

    // All stimulus tasks start and end at posedge+1
    task automatic pulse(input logic n, input logic p, input logic pl, input logic u, input logic ng);
        btn_next = n; btn_prev = p; btn_place = pl; btn_undo = u; new_game = ng;
        @(posedge clk); #1;
        btn_next = 1'b0; btn_prev = 1'b0; btn_place = 1'b0; btn_undo = 1'b0; new_game = 1'b0;
    endtask

    task automatic snap();
        @(posedge clk); #1;
        push_exp(K_SNAP);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic new_game_snap();
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_board = 18'd0; exp_cursor = 4'd5; exp_turn = 1'b0;
        exp_result = 2'b00; exp_over = 1'b0;
        push_exp(K_SNAP);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic goto(input logic [3:0] target);
        for (int k = 0; k < 9 && exp_cursor != target; k++) begin
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_cursor = (exp_cursor == 4'd9) ? 4'd1 : exp_cursor + 4'd1;
        end
    endtask

    // Accepted move; detectors are driven during the CHECK cycle
    task automatic place_move(input logic [1:0] mark, input logic wx, input logic wo,
                              input logic ns, input logic [1:0] res);
        exp_board[exp_cursor - 4'd1] = mark;
        exp_turn = (mark == 2'b01);
        push_exp(K_ACC);
        if (res != 2'b00) begin
            exp_result = res;
            exp_over   = 1'b1;
            push_exp(K_OVER);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        win_x = wx; win_o = wo; no_space = ns;
        @(posedge clk); #1;
        win_x = 1'b0; win_o = 1'b0; no_space = 1'b0;
    endtask

    // Monitor: classify the visible event each cycle and compare against the queue head
    initial begin
        logic       prev_over;
        logic       have_ev;
        logic [1:0] act_kind;
        exp_t       e;
        prev_over = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && !mon_stop) begin
                if (move_accepted && move_rejected) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_excl: accepted=%0b rejected=%0b, required not both high",
                             move_accepted, move_rejected);
                end
                have_ev  = 1'b1;
                act_kind = K_SNAP;
                if (move_accepted)               act_kind = K_ACC;
                else if (move_rejected)          act_kind = K_REJ;
                else if (game_over && !prev_over) act_kind = K_OVER;
                else if (snap_req)               act_kind = K_SNAP;
                else                             have_ev = 1'b0;
                if (have_ev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d, required none", act_kind);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != act_kind ||
                            e.board != {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} ||
                            e.cursor != cursor || e.turn != turn ||
                            e.result != result || e.over != game_over) begin
                            errors++;
                            $display("FAIL event#%0d: got kind=%0d board=%h cur=%0d turn=%0b res=%b over=%0b, required kind=%0d board=%h cur=%0d turn=%0b res=%b over=%0b",
                                     checks, act_kind,
                                     {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1},
                                     cursor, turn, result, game_over,
                                     e.kind, e.board, e.cursor, e.turn, e.result, e.over);
                        end
                    end
                end
            end
            prev_over = game_over;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] draw_cells [9];
        draw_cells = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
        rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_place = 1'b0;
        btn_undo = 1'b0; new_game = 1'b0; win_x = 1'b0; win_o = 1'b0; no_space = 1'b0;
        exp_board = 18'd0; exp_cursor = 4'd5; exp_turn = 1'b0;
        exp_result = 2'b00; exp_over = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();

        // Cursor 5 -> 8, X places at 8
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); exp_cursor = 4'd6;
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); exp_cursor = 4'd7;
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); exp_cursor = 4'd8;
        place_move(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);

        // O tries occupied cell 8
        push_exp(K_REJ);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        snap();

        // next+prev together leaves cursor alone
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        snap();

        // X wins on 1,2,3 with O on 4,5
        new_game_snap();
        repeat (4) pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cursor = 4'd1;
        place_move(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        goto(4'd4);
        place_move(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cursor = 4'd2;
        place_move(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        goto(4'd5);
        place_move(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cursor = 4'd3;
        place_move(2'b01, 1'b1, 1'b0, 1'b0, 2'b01);

        // OVER ignores place and navigation
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        snap();

        // new_game from OVER, then prev wraps 1 -> 9
        new_game_snap();
        goto(4'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_cursor = 4'd9;
        snap();

        // Draw game: full board, no winner
        for (int i = 0; i < 9; i++) begin
            goto(draw_cells[i]);
            if (i == 8) place_move(2'b01, 1'b0, 1'b0, 1'b1, 2'b11);
            else        place_move((i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        end

        // Same board, but win_o with no_space on the ninth move
        new_game_snap();
        for (int i = 0; i < 9; i++) begin
            goto(draw_cells[i]);
            if (i == 8) place_move(2'b01, 1'b0, 1'b1, 1'b1, 2'b10);
            else        place_move((i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        end

        // Undo after X places at 5
        new_game_snap();
        place_move(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_cursor = 4'd6;
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef BOARD_UNDO_EN
        exp_board[4] = 2'b00; exp_turn = 1'b0; exp_cursor = 4'd5;
`endif
        snap();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        snap();

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        mon_stop = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected events outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
